// File: rtl/rob_retire_if.sv
// -----------------------------------------------------------------------------
// rob_retire_if
//
// Purpose:
//   Groups every non-clock/reset signal of the reorder buffer into one
//   interface: dispatch allocation, FU completion, the free-pool push
//   channel, the architectural commit report and the occupancy status.
//
// Modports:
//   slave  - the reorder buffer itself. It consumes allocation, completion
//            and free_full, and produces ready/index, push, commit and status.
//   master - the surrounding pipeline (dispatch, FU lanes, free pool, areg
//            file), which is the mirror image of the slave view.
//
// Signal summary:
//   alloc_valid / alloc_ready / alloc_rob_num   dispatch handshake + index
//   alloc_reg_write, alloc_rd, alloc_old_rd,
//   alloc_ard, alloc_pc                         entry payload
//   cmpl_valid[2:0], cmpl_rob_num[3*IDX-1:0]    per-lane completion
//   free_full / free_push / free_reg            free-pool push channel
//   commit_valid, commit_ard, commit_prd,
//   commit_pc                                   committed mapping
//   rob_count, rob_empty, rob_full              occupancy status
// -----------------------------------------------------------------------------
interface rob_retire_if #(
    parameter int ROB_IDX_WIDTH = 4,
    parameter int PREG_WIDTH    = 6,
    parameter int AREG_WIDTH    = 5,
    parameter int PC_WIDTH      = 12,
    parameter int NUM_LANES     = 3
);
    // Dispatch side
    logic                              alloc_valid;
    logic                              alloc_ready;
    logic                              alloc_reg_write;
    logic [PREG_WIDTH-1:0]             alloc_rd;
    logic [PREG_WIDTH-1:0]             alloc_old_rd;
    logic [AREG_WIDTH-1:0]             alloc_ard;
    logic [PC_WIDTH-1:0]               alloc_pc;
    logic [ROB_IDX_WIDTH-1:0]          alloc_rob_num;

    // Completion lanes
    logic [NUM_LANES-1:0]              cmpl_valid;
    logic [NUM_LANES*ROB_IDX_WIDTH-1:0] cmpl_rob_num;

    // Free-pool push channel
    logic                              free_full;
    logic                              free_push;
    logic [PREG_WIDTH-1:0]             free_reg;

    // Commit report
    logic                              commit_valid;
    logic [AREG_WIDTH-1:0]             commit_ard;
    logic [PREG_WIDTH-1:0]             commit_prd;
    logic [PC_WIDTH-1:0]               commit_pc;

    // Status
    logic [ROB_IDX_WIDTH:0]            rob_count;
    logic                              rob_empty;
    logic                              rob_full;

    modport slave (
        input  alloc_valid, alloc_reg_write, alloc_rd, alloc_old_rd,
               alloc_ard, alloc_pc,
        input  cmpl_valid, cmpl_rob_num,
        input  free_full,
        output alloc_ready, alloc_rob_num,
        output free_push, free_reg,
        output commit_valid, commit_ard, commit_prd, commit_pc,
        output rob_count, rob_empty, rob_full
    );

    modport master (
        output alloc_valid, alloc_reg_write, alloc_rd, alloc_old_rd,
               alloc_ard, alloc_pc,
        output cmpl_valid, cmpl_rob_num,
        output free_full,
        input  alloc_ready, alloc_rob_num,
        input  free_push, free_reg,
        input  commit_valid, commit_ard, commit_prd, commit_pc,
        input  rob_count, rob_empty, rob_full
    );
endinterface

// File: rtl/rob_retire.sv
// -----------------------------------------------------------------------------
// rob_retire
//
// Purpose:
//   16-entry in-order reorder buffer. Dispatch allocates one entry per cycle
//   at the tail, up to three FU lanes mark entries done, and at most one
//   entry per cycle retires from the head in program order. A retiring entry
//   returns its old physical destination to the free pool and reports its
//   committed mapping (ard -> rd, pc) to the architectural register file.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-low reset
//   bus  - rob_retire_if.slave (allocation, completion, free-pool push,
//          commit report, status); see rob_retire_if.sv
//
// Timing:
//   alloc_ready, alloc_rob_num, rob_count/empty/full are functions of the
//   current registers only. Commit and push outputs are registered and
//   appear one cycle after the edge at which the retire decision was taken.
// -----------------------------------------------------------------------------
module rob_retire #(
    parameter int ROB_DEPTH     = 16,
    parameter int ROB_IDX_WIDTH = 4,
    parameter int PREG_WIDTH    = 6,
    parameter int AREG_WIDTH    = 5,
    parameter int PC_WIDTH      = 12
) (
    input  logic         clk,
    input  logic         rst,
    rob_retire_if.slave  bus
);

    localparam int NUM_LANES = 3;
    localparam logic [ROB_IDX_WIDTH:0]   FULL_COUNT = (ROB_IDX_WIDTH+1)'(ROB_DEPTH);
    localparam logic [ROB_IDX_WIDTH:0]   CNT_ONE    = (ROB_IDX_WIDTH+1)'(1);
    localparam logic [ROB_IDX_WIDTH-1:0] IDX_ONE    = ROB_IDX_WIDTH'(1);

    // -------------------------------------------------------------------------
    // Pointers, occupancy and per-entry status bits (reset)
    // -------------------------------------------------------------------------
    logic [ROB_IDX_WIDTH-1:0] head_q, head_d;
    logic [ROB_IDX_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_IDX_WIDTH:0]   count_q, count_d;
    logic [ROB_DEPTH-1:0]     valid_q, valid_d;
    logic [ROB_DEPTH-1:0]     done_q, done_d;

    // -------------------------------------------------------------------------
    // Entry payload (no reset: only ever read behind a valid bit)
    // -------------------------------------------------------------------------
    logic                  rw_mem_q     [ROB_DEPTH];
    logic [PREG_WIDTH-1:0] rd_mem_q     [ROB_DEPTH];
    logic [PREG_WIDTH-1:0] old_rd_mem_q [ROB_DEPTH];
    logic [AREG_WIDTH-1:0] ard_mem_q    [ROB_DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem_q     [ROB_DEPTH];

    // -------------------------------------------------------------------------
    // Registered retire outputs
    // -------------------------------------------------------------------------
    logic                  commit_valid_q, commit_valid_d;
    logic                  free_push_q,    free_push_d;
    logic [PREG_WIDTH-1:0] free_reg_q,     free_reg_d;
    logic [AREG_WIDTH-1:0] commit_ard_q,   commit_ard_d;
    logic [PREG_WIDTH-1:0] commit_prd_q,   commit_prd_d;
    logic [PC_WIDTH-1:0]   commit_pc_q,    commit_pc_d;

    // -------------------------------------------------------------------------
    // Handshake decisions
    // -------------------------------------------------------------------------
    logic                  alloc_ready_w;
    logic                  alloc_fire;
    logic                  head_valid;
    logic                  head_done;
    logic                  head_rw;
    logic                  retire_fire;

    // Allocation looks at the pre-edge count only: a full ROB refuses a new
    // entry even when the head retires in the same cycle.
    assign alloc_ready_w = (count_q != FULL_COUNT);
    assign alloc_fire    = bus.alloc_valid && alloc_ready_w;

    assign head_valid    = valid_q[head_q];
    assign head_done     = done_q[head_q];
    assign head_rw       = rw_mem_q[head_q];

    // Only register-writing entries need a free-pool slot, so a full pool
    // stalls just those; non-writing entries retire regardless.
    assign retire_fire   = head_valid && head_done && (!head_rw || !bus.free_full);

    // -------------------------------------------------------------------------
    // Per-entry valid/done next state
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
            logic cmpl_hit;
            logic alloc_here;
            logic retire_here;

            // Any lane naming this slot; several lanes hitting it is harmless.
            always_comb begin
                cmpl_hit = 1'b0;
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (bus.cmpl_valid[l] &&
                        (bus.cmpl_rob_num[l*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] ==
                         ROB_IDX_WIDTH'(gi))) begin
                        cmpl_hit = 1'b1;
                    end
                end
            end

            assign alloc_here  = alloc_fire  && (tail_q == ROB_IDX_WIDTH'(gi));
            assign retire_here = retire_fire && (head_q == ROB_IDX_WIDTH'(gi));

            // Priority: allocation (fresh entry, not done) over retirement
            // (slot freed) over completion. Completion only lands on a slot
            // that is already valid, so stale strobes to empty slots vanish.
            assign valid_d[gi] = alloc_here  ? 1'b1 :
                                 retire_here ? 1'b0 :
                                 valid_q[gi];
            assign done_d[gi]  = alloc_here  ? 1'b0 :
                                 retire_here ? 1'b0 :
                                 (done_q[gi] | (cmpl_hit & valid_q[gi]));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pointer / count / output next state
    // -------------------------------------------------------------------------
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q;

        // Pointers are exactly ROB_IDX_WIDTH bits, so they wrap 15 -> 0.
        if (retire_fire) begin
            head_d = head_q + IDX_ONE;
        end
        if (alloc_fire) begin
            tail_d = tail_q + IDX_ONE;
        end

        if (alloc_fire && !retire_fire) begin
            count_d = count_q + CNT_ONE;
        end else if (!alloc_fire && retire_fire) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_comb begin
        // Strobes are single-cycle; data holds its last value between retires.
        commit_valid_d = retire_fire;
        free_push_d    = retire_fire && head_rw;
        free_reg_d     = free_reg_q;
        commit_ard_d   = commit_ard_q;
        commit_prd_d   = commit_prd_q;
        commit_pc_d    = commit_pc_q;

        if (retire_fire) begin
            free_reg_d   = old_rd_mem_q[head_q];
            commit_ard_d = ard_mem_q[head_q];
            commit_prd_d = rd_mem_q[head_q];
            commit_pc_d  = pc_mem_q[head_q];
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            done_q         <= '0;
            commit_valid_q <= 1'b0;
            free_push_q    <= 1'b0;
            free_reg_q     <= '0;
            commit_ard_q   <= '0;
            commit_prd_q   <= '0;
            commit_pc_q    <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            valid_q        <= valid_d;
            done_q         <= done_d;
            commit_valid_q <= commit_valid_d;
            free_push_q    <= free_push_d;
            free_reg_q     <= free_reg_d;
            commit_ard_q   <= commit_ard_d;
            commit_prd_q   <= commit_prd_d;
            commit_pc_q    <= commit_pc_d;
        end
    end

    // Payload is written once at allocation and read only at the head.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rw_mem_q[tail_q]     <= bus.alloc_reg_write;
            rd_mem_q[tail_q]     <= bus.alloc_rd;
            old_rd_mem_q[tail_q] <= bus.alloc_old_rd;
            ard_mem_q[tail_q]    <= bus.alloc_ard;
            pc_mem_q[tail_q]     <= bus.alloc_pc;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.alloc_ready   = alloc_ready_w;
    assign bus.alloc_rob_num = tail_q;
    assign bus.rob_count     = count_q;
    assign bus.rob_empty     = (count_q == '0);
    assign bus.rob_full      = (count_q == FULL_COUNT);

    assign bus.commit_valid  = commit_valid_q;
    assign bus.commit_ard    = commit_ard_q;
    assign bus.commit_prd    = commit_prd_q;
    assign bus.commit_pc     = commit_pc_q;
    assign bus.free_push     = free_push_q;
    assign bus.free_reg      = free_reg_q;

endmodule

// File: tb/tb_rob_retire.sv
// -----------------------------------------------------------------------------
// tb_rob_retire
//
// Directed bench for rob_retire: a vector table for the in-order retire
// sequence plus hand-written sequences for full, backpressure, wrap-around
// and asynchronous reset. Inputs change 1 ns after the rising edge, and
// outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_rob_retire;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rob_retire_if #(.ROB_IDX_WIDTH(4), .PREG_WIDTH(6), .AREG_WIDTH(5),
                    .PC_WIDTH(12), .NUM_LANES(3)) rif ();

    rob_retire dut (
        .clk (clk),
        .rst (rst),
        .bus (rif)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.alloc_valid     = 1'b0;
        rif.alloc_reg_write = 1'b0;
        rif.alloc_rd        = '0;
        rif.alloc_old_rd    = '0;
        rif.alloc_ard       = '0;
        rif.alloc_pc        = '0;
        rif.cmpl_valid      = '0;
        rif.cmpl_rob_num    = '0;
        rif.free_full       = 1'b0;
    endtask

    task automatic drive_alloc(input logic rw, input logic [5:0] rd,
                               input logic [5:0] old_rd, input logic [4:0] ard,
                               input logic [11:0] pc);
        rif.alloc_valid     = 1'b1;
        rif.alloc_reg_write = rw;
        rif.alloc_rd        = rd;
        rif.alloc_old_rd    = old_rd;
        rif.alloc_ard       = ard;
        rif.alloc_pc        = pc;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic chk_outputs_clear(input string tag);
        chk({tag, "_commit_valid"}, 32'(rif.commit_valid), 32'd0);
        chk({tag, "_free_push"},    32'(rif.free_push),    32'd0);
        chk({tag, "_free_reg"},     32'(rif.free_reg),     32'd0);
        chk({tag, "_commit_ard"},   32'(rif.commit_ard),   32'd0);
        chk({tag, "_commit_prd"},   32'(rif.commit_prd),   32'd0);
        chk({tag, "_commit_pc"},    32'(rif.commit_pc),    32'd0);
        chk({tag, "_count"},        32'(rif.rob_count),    32'd0);
        chk({tag, "_empty"},        32'(rif.rob_empty),    32'd1);
        chk({tag, "_full"},         32'(rif.rob_full),     32'd0);
        chk({tag, "_ready"},        32'(rif.alloc_ready),  32'd1);
        chk({tag, "_rob_num"},      32'(rif.alloc_rob_num), 32'd0);
    endtask

    typedef struct {
        logic        av;
        logic        rw;
        logic [5:0]  rd;
        logic [5:0]  old_rd;
        logic [4:0]  ard;
        logic [11:0] pc;
        logic [2:0]  cv;
        logic [11:0] cn;
        logic [3:0]  e_num;   // alloc_rob_num before the edge
        logic        e_cv;    // after the edge
        logic        e_fp;
        logic [5:0]  e_freg;
        logic [4:0]  e_ard;
        logic [5:0]  e_prd;
        logic [11:0] e_pc;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vt [9];

    // Wrap-test scoreboard
    logic [5:0]  exp_free_q [$];
    logic [3:0]  exp_tail;
    logic [3:0]  cptr;
    logic        prev_cmpl;
    int          exp_cnt;
    int          seq;

    function automatic logic [5:0] old_of(input int k);
        return 6'((k * 5 + 7) % 64);
    endfunction

    initial begin
        // In-order retire: three allocs, idx2 completes first (lane 2), then
        // idx0/idx1 together with a duplicate on lane 2; retires must be 0,1,2.
        vt[0] = '{1'b1, 1'b1, 6'd32, 6'd1, 5'd5, 12'h100, 3'b000, 12'h000,
                  4'd0, 1'b0, 1'b0, 6'd0, 5'd0, 6'd0,  12'h000, 5'd1};
        vt[1] = '{1'b1, 1'b1, 6'd33, 6'd2, 5'd6, 12'h104, 3'b000, 12'h000,
                  4'd1, 1'b0, 1'b0, 6'd0, 5'd0, 6'd0,  12'h000, 5'd2};
        vt[2] = '{1'b1, 1'b1, 6'd34, 6'd3, 5'd7, 12'h108, 3'b000, 12'h000,
                  4'd2, 1'b0, 1'b0, 6'd0, 5'd0, 6'd0,  12'h000, 5'd3};
        vt[3] = '{1'b0, 1'b0, 6'd0,  6'd0, 5'd0, 12'h000, 3'b100, 12'h200,
                  4'd3, 1'b0, 1'b0, 6'd0, 5'd0, 6'd0,  12'h000, 5'd3};
        vt[4] = '{1'b0, 1'b0, 6'd0,  6'd0, 5'd0, 12'h000, 3'b111, 12'h010,
                  4'd3, 1'b0, 1'b0, 6'd0, 5'd0, 6'd0,  12'h000, 5'd3};
        vt[5] = '{1'b0, 1'b0, 6'd0,  6'd0, 5'd0, 12'h000, 3'b000, 12'h000,
                  4'd3, 1'b1, 1'b1, 6'd1, 5'd5, 6'd32, 12'h100, 5'd2};
        vt[6] = '{1'b0, 1'b0, 6'd0,  6'd0, 5'd0, 12'h000, 3'b000, 12'h000,
                  4'd3, 1'b1, 1'b1, 6'd2, 5'd6, 6'd33, 12'h104, 5'd1};
        vt[7] = '{1'b0, 1'b0, 6'd0,  6'd0, 5'd0, 12'h000, 3'b000, 12'h000,
                  4'd3, 1'b1, 1'b1, 6'd3, 5'd7, 6'd34, 12'h108, 5'd0};
        vt[8] = '{1'b0, 1'b0, 6'd0,  6'd0, 5'd0, 12'h000, 3'b000, 12'h000,
                  4'd3, 1'b0, 1'b0, 6'd3, 5'd7, 6'd34, 12'h108, 5'd0};

        // ---------------------------------------------------------------
        // Reset asserted mid-clock: outputs clear with no edge
        // ---------------------------------------------------------------
        rst = 1'b1;
        idle();
        #12;
        rst = 1'b0;
        #1;
        chk_outputs_clear("reset");
        $display("reset: asserted at %0t, outputs checked before any edge", $time);
        tick();
        rst = 1'b1;

        // ---------------------------------------------------------------
        // Table: in-order retire
        // ---------------------------------------------------------------
        for (int i = 0; i < 9; i++) begin
            idle();
            if (vt[i].av) drive_alloc(vt[i].rw, vt[i].rd, vt[i].old_rd,
                                      vt[i].ard, vt[i].pc);
            rif.cmpl_valid   = vt[i].cv;
            rif.cmpl_rob_num = vt[i].cn;
            #1;
            chk("tbl_rob_num", 32'(rif.alloc_rob_num), 32'(vt[i].e_num));
            tick();
            chk("tbl_commit_valid", 32'(rif.commit_valid), 32'(vt[i].e_cv));
            chk("tbl_free_push",    32'(rif.free_push),    32'(vt[i].e_fp));
            chk("tbl_free_reg",     32'(rif.free_reg),     32'(vt[i].e_freg));
            chk("tbl_commit_ard",   32'(rif.commit_ard),   32'(vt[i].e_ard));
            chk("tbl_commit_prd",   32'(rif.commit_prd),   32'(vt[i].e_prd));
            chk("tbl_commit_pc",    32'(rif.commit_pc),    32'(vt[i].e_pc));
            chk("tbl_count",        32'(rif.rob_count),    32'(vt[i].e_cnt));
            $display("vec %0d: av=%0b cv=%b -> commit_valid=%0b free_reg=%0d count=%0d",
                     i, vt[i].av, vt[i].cv, rif.commit_valid, rif.free_reg, rif.rob_count);
        end

        // ---------------------------------------------------------------
        // Full ROB
        // ---------------------------------------------------------------
        idle();
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            drive_alloc(1'b1, 6'(i + 16), 6'(i + 40), 5'(i), 12'(i));
            chk("full_rob_num", 32'(rif.alloc_rob_num), 32'(i));
            tick();
        end
        chk("full_count",   32'(rif.rob_count),     32'd16);
        chk("full_flag",    32'(rif.rob_full),      32'd1);
        chk("full_ready",   32'(rif.alloc_ready),   32'd0);
        chk("full_rob_num", 32'(rif.alloc_rob_num), 32'd0);
        // 17th request held high; complete head in the same cycle
        rif.cmpl_valid   = 3'b001;
        rif.cmpl_rob_num = 12'h000;
        tick();
        rif.cmpl_valid   = 3'b000;
        chk("full17_count",   32'(rif.rob_count),     32'd16);
        chk("full17_rob_num", 32'(rif.alloc_rob_num), 32'd0);
        chk("full17_commit",  32'(rif.commit_valid),  32'd0);
        $display("full: 17th alloc refused, count=%0d", rif.rob_count);
        // Head retires; allocation still refused at this edge (no bypass)
        tick();
        chk("fullret_count",   32'(rif.rob_count),     32'd15);
        chk("fullret_ready",   32'(rif.alloc_ready),   32'd1);
        chk("fullret_commit",  32'(rif.commit_valid),  32'd1);
        chk("fullret_free",    32'(rif.free_reg),      32'd40);
        chk("fullret_rob_num", 32'(rif.alloc_rob_num), 32'd0);
        tick();
        chk("fullre_count",   32'(rif.rob_count),     32'd16);
        chk("fullre_rob_num", 32'(rif.alloc_rob_num), 32'd1);
        chk("fullre_commit",  32'(rif.commit_valid),  32'd0);
        $display("full: head retired, slot 0 reallocated, count=%0d", rif.rob_count);

        // ---------------------------------------------------------------
        // Backpressure from the free pool
        // ---------------------------------------------------------------
        idle();
        pulse_reset();
        drive_alloc(1'b1, 6'd20, 6'd9, 5'd3, 12'h200);
        tick();
        drive_alloc(1'b0, 6'd21, 6'd11, 5'd4, 12'h201);
        tick();
        idle();
        rif.cmpl_valid   = 3'b011;
        rif.cmpl_rob_num = 12'h010;
        rif.free_full    = 1'b1;
        tick();
        rif.cmpl_valid = 3'b000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_commit", 32'(rif.commit_valid), 32'd0);
            chk("bp_push",   32'(rif.free_push),    32'd0);
            chk("bp_count",  32'(rif.rob_count),    32'd2);
            $display("backpressure cycle %0d: count=%0d", i, rif.rob_count);
        end
        rif.free_full = 1'b0;
        tick();
        chk("bprel_commit", 32'(rif.commit_valid), 32'd1);
        chk("bprel_push",   32'(rif.free_push),    32'd1);
        chk("bprel_free",   32'(rif.free_reg),     32'd9);
        chk("bprel_ard",    32'(rif.commit_ard),   32'd3);
        chk("bprel_prd",    32'(rif.commit_prd),   32'd20);
        chk("bprel_count",  32'(rif.rob_count),    32'd1);
        rif.free_full = 1'b1;
        tick();
        chk("bpnw_commit", 32'(rif.commit_valid), 32'd1);
        chk("bpnw_push",   32'(rif.free_push),    32'd0);
        chk("bpnw_ard",    32'(rif.commit_ard),   32'd4);
        chk("bpnw_prd",    32'(rif.commit_prd),   32'd21);
        chk("bpnw_free",   32'(rif.free_reg),     32'd11);
        chk("bpnw_count",  32'(rif.rob_count),    32'd0);
        rif.free_full = 1'b0;
        tick();
        chk("bpend_commit", 32'(rif.commit_valid), 32'd0);
        chk("bpend_push",   32'(rif.free_push),    32'd0);
        $display("backpressure: released, non-writing entry retired past full pool");

        // ---------------------------------------------------------------
        // Wrap-around at steady occupancy 3 (tail starts at 2)
        // ---------------------------------------------------------------
        idle();
        exp_tail  = 4'd2;
        cptr      = 4'd2;
        prev_cmpl = 1'b0;
        exp_cnt   = 0;
        seq       = 0;
        for (int k = 0; k < 2; k++) begin
            drive_alloc(1'b1, 6'(seq), old_of(seq), 5'(seq), 12'(seq));
            chk("wrap_pre_num", 32'(rif.alloc_rob_num), 32'(exp_tail));
            exp_free_q.push_back(old_of(seq));
            seq++;
            tick();
            exp_tail = exp_tail + 4'd1;
            exp_cnt++;
        end
        for (int n = 0; n < 44; n++) begin
            logic do_alloc;
            logic do_cmpl;
            idle();
            do_alloc = (n < 40);
            do_cmpl  = (cptr != exp_tail) || do_alloc;
            if (do_alloc) begin
                drive_alloc(1'b1, 6'(seq), old_of(seq), 5'(seq), 12'(seq));
                chk("wrap_num", 32'(rif.alloc_rob_num), 32'(exp_tail));
                exp_free_q.push_back(old_of(seq));
                seq++;
            end
            if (do_cmpl) begin
                rif.cmpl_valid   = 3'(1 << (n % 3));
                rif.cmpl_rob_num = 12'(cptr) << ((n % 3) * 4);
            end
            tick();
            chk("wrap_commit", 32'(rif.commit_valid), 32'(prev_cmpl));
            if (prev_cmpl) begin
                chk("wrap_free_reg", 32'(rif.free_reg), 32'(exp_free_q.pop_front()));
                exp_cnt--;
            end
            if (do_alloc) begin
                exp_tail = exp_tail + 4'd1;
                exp_cnt++;
            end
            chk("wrap_count", 32'(rif.rob_count), 32'(exp_cnt));
            $display("wrap %0d: commit_valid=%0b free_reg=%0d count=%0d",
                     n, rif.commit_valid, rif.free_reg, rif.rob_count);
            if (do_cmpl) cptr = cptr + 4'd1;
            prev_cmpl = do_cmpl;
        end
        chk("wrap_drained", 32'(rif.rob_count), 32'd0);

        // ---------------------------------------------------------------
        // Asynchronous reset with live entries, then stale completion
        // ---------------------------------------------------------------
        idle();
        for (int k = 0; k < 6; k++) begin
            drive_alloc(1'b1, 6'(50 + k), 6'(20 + k), 5'(10 + k), 12'(12'h300 + k));
            tick();
        end
        idle();
        rif.cmpl_valid   = 3'b011;
        rif.cmpl_rob_num = {4'd0, 4'(exp_tail + 4'd3), 4'(exp_tail)};
        tick();
        rif.cmpl_valid   = 3'b100;
        rif.cmpl_rob_num = {4'(exp_tail + 4'd4), 8'd0};
        tick();
        chk("pre_rst_commit", 32'(rif.commit_valid), 32'd1);
        chk("pre_rst_free",   32'(rif.free_reg),     32'd20);
        chk("pre_rst_count",  32'(rif.rob_count),    32'd5);
        idle();
        #3;
        rst = 1'b0;
        #1;
        chk_outputs_clear("async_rst");
        $display("async reset: asserted at %0t with 5 live entries", $time);
        tick();
        chk("rst_hold_count", 32'(rif.rob_count), 32'd0);
        rst = 1'b1;
        // Stale completion for idx 1 while idx 1 is empty
        rif.cmpl_valid   = 3'b001;
        rif.cmpl_rob_num = 12'h001;
        tick();
        idle();
        drive_alloc(1'b1, 6'd60, 6'd30, 5'd1, 12'h400);
        chk("post_rst_num0", 32'(rif.alloc_rob_num), 32'd0);
        tick();
        drive_alloc(1'b1, 6'd61, 6'd31, 5'd2, 12'h401);
        chk("post_rst_num1", 32'(rif.alloc_rob_num), 32'd1);
        tick();
        idle();
        rif.cmpl_valid   = 3'b001;
        rif.cmpl_rob_num = 12'h000;
        tick();
        idle();
        tick();
        chk("stale_commit0", 32'(rif.commit_valid), 32'd1);
        chk("stale_free0",   32'(rif.free_reg),     32'd30);
        chk("stale_count0",  32'(rif.rob_count),    32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stale_commit1", 32'(rif.commit_valid), 32'd0);
            chk("stale_count1",  32'(rif.rob_count),    32'd1);
        end
        $display("stale completion: idx 1 stays not-done, count=%0d", rif.rob_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
